// File: rtl/mem_bus_fabric.sv
// rtl/mem_bus_fabric.sv - master-to-N-slave memory bus fabric with decode, timeout and sticky error report
module mem_bus_fabric #(
  parameter int                       NUM_SLAVES     = 5,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFF0_0000}},
  parameter int                       TIMEOUT_CYCLES = 256,
  parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_valid,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  output logic                       err_irq,
  output logic [1:0]                 err_cause,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state, nxt;
  logic [SW-1:0] sel, hit_idx;
  logic [CW-1:0] cnt;
  logic          hit, go_ok, go_err, timeout_hit;
  logic [1:0]    new_cause;
  logic [31:0]   rdata_arr [NUM_SLAVES];

  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;
  assign m_ready = (state == RESP);

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_rd
    assign rdata_arr[k] = s_rdata[32*k +: 32];
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((m_addr & SLAVE_MASK[32*k +: 32]) == (SLAVE_BASE[32*k +: 32] & SLAVE_MASK[32*k +: 32])) begin
        hit     = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

  always_comb begin
    s_valid = '0;
    if (state == ACTIVE && m_valid) s_valid[sel] = 1'b1;
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_comb begin
    nxt       = state;
    go_ok     = 1'b0;
    go_err    = 1'b0;
    new_cause = 2'b00;
    case (state)
      IDLE: begin
        if (m_valid) begin
          if (hit) begin
            nxt = ACTIVE;
          end else begin
            nxt       = RESP;
            go_err    = 1'b1;
            new_cause = 2'b01;
          end
        end
      end
      ACTIVE: begin
        if (!m_valid) begin
          nxt = IDLE;
        end else if (s_ready[sel]) begin
          nxt   = RESP;
          go_ok = 1'b1;
        end else if (timeout_hit) begin
          nxt       = RESP;
          go_err    = 1'b1;
          new_cause = 2'b10;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      m_rdata   <= '0;
      err_irq   <= 1'b0;
      err_cause <= 2'b00;
      err_addr  <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == ACTIVE) ? cnt + 1'b1 : '0;
      if (state == IDLE && m_valid && hit) sel <= hit_idx;
      if (go_ok)       m_rdata <= rdata_arr[sel];
      else if (go_err) m_rdata <= ERR_RDATA;
      // A clear wins over an error arriving in the same cycle; that error is lost.
      if (err_clr) begin
        err_irq   <= 1'b0;
        err_cause <= 2'b00;
        err_addr  <= '0;
      end else if (go_err && !err_irq) begin
        err_irq   <= 1'b1;
        err_cause <= new_cause;
        err_addr  <= m_addr;
      end
    end
  end

endmodule
